// File: rtl/readout_controller_pkg.sv
// Shared pixel-sensor configuration: array geometry, readout timing and the
// readout sequencer state encoding.
`timescale 1ns/1ps
package PixelSensorConfig;

  localparam int PIXEL_ARRAY_WIDTH  = 64;
  localparam int PIXEL_ARRAY_HEIGHT = 8;
  localparam int OUTPUT_BUS_WIDTH   = 16;
  localparam int READOUT_ROW_SETTLE = 2;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SETTLE,
    RD_LOAD,
    RD_DRAIN,
    RD_NEXT,
    RD_DONE
  } readout_state_t;

  // Width of an address that selects one of n items, never narrower than 1.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/readout_controller_counter.sv
// Up-counter with synchronous clear/enable and a terminal flag raised when the
// count equals a caller-supplied limit.
`timescale 1ns/1ps
module readout_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count    = count_reg;
  assign terminal = (count_reg == limit);

endmodule

// File: rtl/readout_controller.sv
// Frame readout sequencer: settles each row, strobes it into the output buffer
// and paces the buffer shift-out over a valid/ready bus, row by row.
`timescale 1ns/1ps
module readout_controller
  import PixelSensorConfig::*;
#(
  parameter int ROWS          = PIXEL_ARRAY_HEIGHT,
  parameter int BEATS_PER_ROW = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH,
  parameter int ROW_SETTLE    = READOUT_ROW_SETTLE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  output logic [sel_width(ROWS)-1:0] row_sel,
  output logic                       row_read,
  output logic                       buf_load,
  output logic                       buf_shift,
  output logic                       beat_valid,
  input  logic                       beat_ready,
  output logic                       row_last,
  output logic                       frame_last,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = sel_width(ROWS);
  localparam int BW = $clog2(BEATS_PER_ROW + 1);
  localparam int SW = $clog2(ROW_SETTLE + 1);

  localparam logic [RW-1:0] ROW_LIMIT    = RW'(ROWS - 1);
  localparam logic [BW-1:0] BEAT_LIMIT   = BW'(BEATS_PER_ROW - 1);
  localparam logic [SW-1:0] SETTLE_LIMIT = SW'(ROW_SETTLE - 1);

  readout_state_t state_reg;

  logic [RW-1:0] row_count;
  logic [BW-1:0] beat_count;
  logic [SW-1:0] settle_count;
  logic          row_term, beat_term, settle_term;
  logic          transfer;
  logic          unused_counts;

  // Beat and settle counts are only observed through their terminal flags.
  assign unused_counts = ^{beat_count, settle_count};

  assign transfer = (state_reg == RD_DRAIN) && beat_ready && !abort;

  readout_counter #(.WIDTH(RW)) u_row_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort || (state_reg == RD_IDLE) || (state_reg == RD_DONE)),
    .enable   ((state_reg == RD_NEXT) && !row_term),
    .limit    (ROW_LIMIT),
    .count    (row_count),
    .terminal (row_term)
  );

  readout_counter #(.WIDTH(BW)) u_beat_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort || (state_reg != RD_DRAIN)),
    .enable   (transfer),
    .limit    (BEAT_LIMIT),
    .count    (beat_count),
    .terminal (beat_term)
  );

  readout_counter #(.WIDTH(SW)) u_settle_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort || (state_reg != RD_SETTLE)),
    .enable   (state_reg == RD_SETTLE),
    .limit    (SETTLE_LIMIT),
    .count    (settle_count),
    .terminal (settle_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RD_IDLE;
    end else if (abort) begin
      state_reg <= RD_IDLE;
    end else begin
      case (state_reg)
        RD_IDLE:   if (start) state_reg <= RD_SETTLE;
        RD_SETTLE: if (settle_term) state_reg <= RD_LOAD;
        RD_LOAD:   state_reg <= RD_DRAIN;
        RD_DRAIN:  if (transfer && beat_term) state_reg <= RD_NEXT;
        RD_NEXT:   state_reg <= row_term ? RD_DONE : RD_SETTLE;
        RD_DONE:   state_reg <= RD_IDLE;
        default:   state_reg <= RD_IDLE;
      endcase
    end
  end

  assign row_sel    = row_count;
  assign row_read   = (state_reg == RD_SETTLE) || (state_reg == RD_LOAD);
  assign buf_load   = (state_reg == RD_LOAD);
  assign beat_valid = (state_reg == RD_DRAIN);
  assign buf_shift  = transfer;
  assign row_last   = beat_valid && beat_term;
  assign frame_last = row_last && row_term;
  assign busy       = (state_reg != RD_IDLE);
  assign done       = (state_reg == RD_DONE);

endmodule

// File: tb/tb_readout_controller.sv
// Directed bench for readout_controller: a 4x4 (settle 2) instance for most
// scenarios plus a 1x1 (settle 1) instance for the minimal configuration.
`timescale 1ns/1ps
module tb_readout_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, beat_ready;
  logic [1:0] row_sel;
  logic       row_read, buf_load, buf_shift, beat_valid;
  logic       row_last, frame_last, busy, done;

  logic       m_start, m_abort, m_beat_ready;
  logic [0:0] m_row_sel;
  logic       m_row_read, m_buf_load, m_buf_shift, m_beat_valid;
  logic       m_row_last, m_frame_last, m_busy, m_done;

  logic [9:0] outs;
  int         errors = 0;
  int         checks = 0;

  assign outs = {row_sel, row_read, buf_load, buf_shift, beat_valid,
                 row_last, frame_last, busy, done};

  always #5 clk = ~clk;

  readout_controller #(.ROWS(4), .BEATS_PER_ROW(4), .ROW_SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .row_sel(row_sel), .row_read(row_read), .buf_load(buf_load),
    .buf_shift(buf_shift), .beat_valid(beat_valid), .beat_ready(beat_ready),
    .row_last(row_last), .frame_last(frame_last), .busy(busy), .done(done)
  );

  readout_controller #(.ROWS(1), .BEATS_PER_ROW(1), .ROW_SETTLE(1)) dut_min (
    .clk(clk), .reset(reset), .start(m_start), .abort(m_abort),
    .row_sel(m_row_sel), .row_read(m_row_read), .buf_load(m_buf_load),
    .buf_shift(m_buf_shift), .beat_valid(m_beat_valid), .beat_ready(m_beat_ready),
    .row_last(m_row_last), .frame_last(m_frame_last), .busy(m_busy), .done(m_done)
  );

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; abort = 1'b0; beat_ready = 1'b1;
    m_start = 1'b0; m_abort = 1'b0; m_beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", outs, 10'b0);
    end
    start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (outs !== 10'b0 || m_busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got %b/%b expected 0/0", outs, m_busy);
    end
    $display("test_reset: outs=%b", outs);
  endtask

  task automatic test_full_frame();
    int first_load = -1, first_valid = -1, shifts = 0, fl_beat = -1, fl_cnt = 0;
    int done_cyc = -1, done_cnt = 0, busy_low = -1, loads = 0, rl_cnt = 0;
    int rows_seen[4];
    for (int i = 0; i < 4; i++) rows_seen[i] = -1;
    @(negedge clk); start = 1'b1; beat_ready = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (buf_load) begin
        if (first_load < 0) first_load = c;
        if (loads < 4) rows_seen[loads] = int'(row_sel);
        loads++;
      end
      if (beat_valid && first_valid < 0) first_valid = c;
      if (frame_last) fl_cnt++;
      if (buf_shift) begin
        shifts++;
        if (row_last) rl_cnt++;
        if (frame_last) fl_beat = shifts;
      end
      if (done) begin done_cnt++; done_cyc = c; end
      if (!busy && busy_low < 0) busy_low = c;
    end
    checks++; if (first_load !== 3) begin errors++; $display("FAIL full_load_cycle: got %0d expected 3", first_load); end
    checks++; if (first_valid !== 4) begin errors++; $display("FAIL full_first_valid: got %0d expected 4", first_valid); end
    checks++; if (shifts !== 16) begin errors++; $display("FAIL full_shifts: got %0d expected 16", shifts); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rows_seen[i] !== i) begin errors++; $display("FAIL full_row_sel[%0d]: got %0d expected %0d", i, rows_seen[i], i); end
    end
    checks++; if (rl_cnt !== 4) begin errors++; $display("FAIL full_row_last_count: got %0d expected 4", rl_cnt); end
    checks++; if (fl_beat !== 16 || fl_cnt !== 1) begin errors++; $display("FAIL full_frame_last: beat %0d count %0d expected beat 16 count 1", fl_beat, fl_cnt); end
    checks++; if (done_cyc !== 33 || done_cnt !== 1) begin errors++; $display("FAIL full_done: cycle %0d count %0d expected cycle 33 count 1", done_cyc, done_cnt); end
    checks++; if (busy_low !== 34) begin errors++; $display("FAIL full_busy_low: got %0d expected 34", busy_low); end
    $display("test_full_frame: load=%0d valid=%0d shifts=%0d done=%0d busy_low=%0d", first_load, first_valid, shifts, done_cyc, busy_low);
  endtask

  task automatic test_backpressure();
    int shifts = 0, done_cnt = 0, done_cyc = -1, seg = 0, segs = 0, bad = 0, dpos = 0;
    @(negedge clk); start = 1'b1; beat_ready = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk); start = 1'b0;
      if (beat_valid) begin beat_ready = (dpos % 2 == 1); dpos++; end
      else begin beat_ready = 1'b0; dpos = 0; end
      #1;
      if (buf_shift) shifts++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (beat_valid) seg++;
      else if (seg > 0) begin segs++; if (seg != 8) bad++; seg = 0; end
    end
    checks++; if (shifts !== 16) begin errors++; $display("FAIL bp_shifts: got %0d expected 16", shifts); end
    checks++; if (segs !== 4 || bad !== 0) begin errors++; $display("FAIL bp_drain_segments: got %0d segs %0d bad expected 4 segs 0 bad", segs, bad); end
    checks++; if (done_cyc !== 49 || done_cnt !== 1) begin errors++; $display("FAIL bp_done: cycle %0d count %0d expected cycle 49 count 1", done_cyc, done_cnt); end
    beat_ready = 1'b1;
    $display("test_backpressure: shifts=%0d segs=%0d done=%0d", shifts, segs, done_cyc);
  endtask

  task automatic test_start_ignored();
    int shifts = 0, done_cnt = 0, done_cyc = -1, extra_busy = 0;
    bit pulsed = 0;
    @(negedge clk); start = 1'b1; beat_ready = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!pulsed && row_read && row_sel == 2'd2) begin start = 1'b1; pulsed = 1; end
      #1;
      if (buf_shift) shifts++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (c > 34 && busy) extra_busy++;
    end
    start = 1'b0;
    checks++; if (!pulsed) begin errors++; $display("FAIL restart_pulse_applied: got 0 expected 1"); end
    checks++; if (done_cnt !== 1 || done_cyc !== 33) begin errors++; $display("FAIL restart_done: count %0d cycle %0d expected count 1 cycle 33", done_cnt, done_cyc); end
    checks++; if (shifts !== 16) begin errors++; $display("FAIL restart_shifts: got %0d expected 16", shifts); end
    checks++; if (extra_busy !== 0) begin errors++; $display("FAIL restart_not_queued: busy cycles %0d expected 0", extra_busy); end
    $display("test_start_ignored: done_cnt=%0d shifts=%0d", done_cnt, shifts);
  endtask

  task automatic test_abort();
    int shifts = 0, done_cnt = 0, after_busy = 0;
    bit aborted = 0;
    @(negedge clk); start = 1'b1; beat_ready = 1'b1;
    for (int c = 1; c <= 30 && !aborted; c++) begin
      @(negedge clk); start = 1'b0;
      if (beat_valid && shifts == 6) begin
        abort = 1'b1; #1;
        checks++;
        if (buf_shift !== 1'b0 || row_sel !== 2'd1) begin
          errors++; $display("FAIL abort_no_shift: shift %b row %0d expected shift 0 row 1", buf_shift, row_sel);
        end
        aborted = 1;
      end else begin
        #1;
        if (buf_shift) shifts++;
        if (done) done_cnt++;
      end
    end
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (!aborted || busy !== 1'b0 || beat_valid !== 1'b0) begin
      errors++; $display("FAIL abort_to_idle: aborted %0d busy %b valid %b expected 1 0 0", aborted, busy, beat_valid);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      if (busy) after_busy++;
      if (done) done_cnt++;
    end
    checks++; if (done_cnt !== 0 || after_busy !== 0) begin errors++; $display("FAIL abort_no_done: done %0d busy %0d expected 0 0", done_cnt, after_busy); end

    // Fresh frame after abort must start from row 0 with clean counters.
    shifts = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (row_read !== 1'b1 || row_sel !== 2'd0) begin
      errors++; $display("FAIL abort_restart_row0: row_read %b row_sel %0d expected 1 0", row_read, row_sel);
    end
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk); #1;
      if (buf_shift) shifts++;
      if (done) begin
        done_cnt++;
        checks++;
        if (c !== 33) begin errors++; $display("FAIL abort_restart_done_cycle: got %0d expected 33", c); end
      end
    end
    checks++; if (shifts !== 16 || done_cnt !== 1) begin errors++; $display("FAIL abort_restart_frame: shifts %0d done %0d expected 16 1", shifts, done_cnt); end
    $display("test_abort: restart shifts=%0d done=%0d", shifts, done_cnt);
  endtask

  task automatic test_abort_start_idle();
    int busy_cnt = 0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1; if (busy) busy_cnt++;
      @(negedge clk);
    end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL abort_beats_start: busy cycles %0d expected 0", busy_cnt); end
    $display("test_abort_start_idle: busy_cycles=%0d", busy_cnt);
  endtask

  task automatic test_reset_mid_load();
    bit found = 0;
    @(negedge clk); start = 1'b1; beat_ready = 1'b1;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clk); start = 1'b0; #1;
      if (buf_load) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach_load: got 0 expected 1"); end
    reset = 1'b0; #1;
    checks++;
    if (buf_load !== 1'b0 || row_read !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_async_drop: load %b read %b busy %b expected 0 0 0", buf_load, row_read, busy);
    end
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (outs !== 10'b0) begin errors++; $display("FAIL rst_release_outputs: got %b expected %b", outs, 10'b0); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_needs_start: busy %b expected 0", busy); end
    $display("test_reset_mid_load: found_load=%0d", found);
  endtask

  task automatic test_minimal();
    int shifts = 0, flag_ok = 0, load_cyc = -1, done_cyc = -1, done_cnt = 0;
    @(negedge clk); m_start = 1'b1; m_beat_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); m_start = 1'b0; #1;
      if (m_buf_load) load_cyc = c;
      if (m_buf_shift) begin
        shifts++;
        if (m_row_last && m_frame_last) flag_ok++;
      end
      if (m_done) begin done_cnt++; done_cyc = c; end
    end
    checks++; if (load_cyc !== 2) begin errors++; $display("FAIL min_load_cycle: got %0d expected 2", load_cyc); end
    checks++; if (shifts !== 1 || flag_ok !== 1) begin errors++; $display("FAIL min_last_flags: shifts %0d flagged %0d expected 1 1", shifts, flag_ok); end
    checks++; if (done_cyc !== 5 || done_cnt !== 1) begin errors++; $display("FAIL min_done: cycle %0d count %0d expected cycle 5 count 1", done_cyc, done_cnt); end
    $display("test_minimal: load=%0d shifts=%0d done=%0d", load_cyc, shifts, done_cyc);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_abort_start_idle();
    test_reset_mid_load();
    test_minimal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
